// File: rtl/mmss_counter.sv
// mmss_counter: minutes:seconds BCD time-keeping core with run/pause, clear and field adjust
module mmss_counter #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int ADJ_HZ  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pause_btn,
  input  logic       clr,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic       running,
  output logic       wrap
);
  localparam int RUN_N = CLK_HZ / TICK_HZ;
  localparam int ADJ_N = CLK_HZ / ADJ_HZ;
  localparam int RW = $clog2(RUN_N + 1);
  localparam int AW = $clog2(ADJ_N + 1);
  typedef enum logic [1:0] {PAUSED, RUN, ADJUST} state_t;
  state_t state, state_nx;
  logic [RW-1:0] run_div;
  logic [AW-1:0] adj_div;
  logic run_tick, adj_tick, inc_sec, inc_min, s1_max, s10_max, m1_max, m10_max;
  logic [3:0] d1_nx, d2_nx, d3_nx, d4_nx;
  // adjust mode dominates; leaving adjust always lands in PAUSED
  always_comb begin
    state_nx = state;
    if (adj) state_nx = ADJUST;
    else if (state == ADJUST) state_nx = PAUSED;
    else if (pause_btn) state_nx = (state == RUN) ? PAUSED : RUN;
  end
  // tick decode and BCD increment; a seconds rollover feeds minutes only while running
  always_comb begin
    run_tick = (state == RUN) && (run_div == RW'(RUN_N - 1));
    adj_tick = (state == ADJUST) && (adj_div == AW'(ADJ_N - 1));
    s1_max   = digit4 == 4'd9;
    s10_max  = digit3 == 4'd5;
    m1_max   = digit2 == 4'd9;
    m10_max  = digit1 == 4'd5;
    inc_sec  = run_tick || (adj_tick && sel);
    inc_min  = (run_tick && s1_max && s10_max) || (adj_tick && !sel);
    d4_nx    = inc_sec ? (s1_max ? 4'd0 : digit4 + 4'd1) : digit4;
    d3_nx    = (inc_sec && s1_max) ? (s10_max ? 4'd0 : digit3 + 4'd1) : digit3;
    d2_nx    = inc_min ? (m1_max ? 4'd0 : digit2 + 4'd1) : digit2;
    d1_nx    = (inc_min && m1_max) ? (m10_max ? 4'd0 : digit1 + 4'd1) : digit1;
  end
  // state, dividers (held at zero outside their mode so the first tick is a full period away) and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PAUSED;
      run_div <= '0;
      adj_div <= '0;
      digit1  <= '0;
      digit2  <= '0;
      digit3  <= '0;
      digit4  <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_nx;
      running <= state_nx == RUN;
      run_div <= (clr || state != RUN || run_tick) ? '0 : run_div + RW'(1);
      adj_div <= (clr || state != ADJUST || adj_tick) ? '0 : adj_div + AW'(1);
      digit1  <= clr ? 4'd0 : d1_nx;
      digit2  <= clr ? 4'd0 : d2_nx;
      digit3  <= clr ? 4'd0 : d3_nx;
      digit4  <= clr ? 4'd0 : d4_nx;
      wrap    <= !clr && run_tick && s1_max && s10_max && m1_max && m10_max;
    end
  end
endmodule

// File: tb/tb_mmss_counter.sv
// tb_mmss_counter: directed vector table plus hand-written corner sequences for mmss_counter
module tb_mmss_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pause_btn = 1'b0, clr = 1'b0, adj = 1'b0, sel = 1'b0;
  logic [3:0] digit1, digit2, digit3, digit4;
  logic running, wrap;
  int n_vec = 0, n_bad = 0;

  mmss_counter #(.CLK_HZ(10), .TICK_HZ(1), .ADJ_HZ(2)) dut (
    .clk(clk), .rst_n(rst_n), .pause_btn(pause_btn), .clr(clr), .adj(adj), .sel(sel),
    .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
    .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic p, c, a, s;
    int n;
    logic [15:0] d;
    logic r, w;
  } vec_t;
  vec_t v[13];

  task automatic check(input string name, input logic [15:0] d, input logic r, input logic w);
    n_vec++;
    if ({digit1, digit2, digit3, digit4, running, wrap} !== {d, r, w}) begin
      n_bad++;
      $display("FAIL %s: got %h%h:%h%h run=%b wrap=%b, expected %h:%h run=%b wrap=%b",
               name, digit1, digit2, digit3, digit4, running, wrap, d[15:8], d[7:0], r, w);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic p, input logic c, input logic a, input logic s, input int n);
    @(negedge clk);
    pause_btn = p; clr = c; adj = a; sel = s;
    @(posedge clk);
    #1;
    pause_btn = 1'b0; clr = 1'b0;
    cyc(n);
  endtask

  initial begin
    int illegal;
    v[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 99, 16'h0000, 1'b0, 1'b0};
    v[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 16'h0001, 1'b1, 1'b0};
    v[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 89, 16'h0010, 1'b1, 1'b0};
    v[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 49, 16'h0010, 1'b0, 1'b0};
    v[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 9,  16'h0010, 1'b1, 1'b0};
    v[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0,  16'h0011, 1'b1, 1'b0};
    v[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0,  16'h0000, 1'b1, 1'b0};
    v[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9,  16'h0001, 1'b1, 1'b0};
    v[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4,  16'h0001, 1'b0, 1'b0};
    v[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0,  16'h0002, 1'b0, 1'b0};
    v[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 4,  16'h0102, 1'b0, 1'b0};
    v[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 0,  16'h0102, 1'b0, 1'b0};
    v[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,  16'h0102, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      apply(v[i].p, v[i].c, v[i].a, v[i].s, v[i].n);
      check($sformatf("vec%0d", i), v[i].d, v[i].r, v[i].w);
    end

    apply(1'b0, 1'b1, 1'b0, 1'b0, 0);
    check("clr_before_wrap_run", 16'h0000, 1'b1, 1'b0);
    illegal = 0;
    for (int i = 0; i < 35990; i++) begin
      cyc(1);
      if (digit1 > 4'd5 || digit2 > 4'd9 || digit3 > 4'd5 || digit4 > 4'd9 || wrap) illegal++;
    end
    n_vec++;
    if (illegal != 0) begin
      n_bad++;
      $display("FAIL digit_range: %0d bad cycles, expected 0", illegal);
    end
    check("at_5959", 16'h5959, 1'b1, 1'b0);
    cyc(10);
    check("wrap_pulse", 16'h0000, 1'b1, 1'b1);
    cyc(1);
    check("wrap_one_clk", 16'h0000, 1'b1, 1'b0);

    cyc(589);
    check("at_0059", 16'h0059, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 49);
    check("frozen_0059", 16'h0059, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 9);
    check("resume_pre_tick", 16'h0059, 1'b1, 1'b0);
    cyc(1);
    check("resume_0100", 16'h0100, 1'b1, 1'b0);

    apply(1'b0, 1'b1, 1'b1, 1'b0, 290);
    check("adj_min_58", 16'h5800, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 149);
    check("adj_sec_30", 16'h5830, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 14);
    check("adj_min_wrap", 16'h0130, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("adj_exit_paused", 16'h0130, 1'b0, 1'b0);

    apply(1'b0, 1'b0, 1'b1, 1'b0, 55);
    check("adj_min_12", 16'h1230, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 19);
    check("adj_1234", 16'h1234, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 8);
    check("run_1234", 16'h1234, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 0);
    check("clr_beats_tick", 16'h0000, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 8);
    check("clr_resets_div", 16'h0000, 1'b1, 1'b0);
    cyc(1);
    check("tick_after_clr", 16'h0001, 1'b1, 1'b0);

    cyc(3);
    rst_n = 1'b0;
    #1;
    check("async_reset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(20);
    check("post_reset_paused", 16'h0000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
